nasti_line_bridge: RTL and testbench

NASTI_LINE_BRIDGE -- requirements
Module: nasti_line_bridge

---
 rtl/nasti_line_bridge.sv | 192 +++++++++++++++++++
 tb/tb_nasti_line_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nasti_line_bridge.sv
// Line-request to NASTI master bridge: each request becomes one INCR burst of LINE_BEATS beats.
// Optional feature macro NASTI_LINE_BRIDGE_ERR_EN: report bad resp codes / r.last mismatches on rsp_err.
module nasti_line_bridge #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned LINE_BEATS = 4,
    parameter int unsigned MASTER_ID  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    // line request / completion
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [LINE_BEATS*DATA_WIDTH-1:0] req_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [LINE_BEATS*DATA_WIDTH-1:0] rsp_rdata,
    output logic                             rsp_err,
    // aw
    output logic                             aw_valid,
    input  logic                             aw_ready,
    output logic [ID_WIDTH-1:0]              aw_id,
    output logic [ADDR_WIDTH-1:0]            aw_addr,
    output logic [7:0]                       aw_len,
    output logic [2:0]                       aw_size,
    output logic [1:0]                       aw_burst,
    output logic [USER_WIDTH-1:0]            aw_user,
    // w
    output logic                             w_valid,
    input  logic                             w_ready,
    output logic [DATA_WIDTH-1:0]            w_data,
    output logic [DATA_WIDTH/8-1:0]          w_strb,
    output logic                             w_last,
    output logic [USER_WIDTH-1:0]            w_user,
    // b
    input  logic                             b_valid,
    output logic                             b_ready,
    input  logic [ID_WIDTH-1:0]              b_id,
    input  logic [1:0]                       b_resp,
    input  logic [USER_WIDTH-1:0]            b_user,
    // ar
    output logic                             ar_valid,
    input  logic                             ar_ready,
    output logic [ID_WIDTH-1:0]              ar_id,
    output logic [ADDR_WIDTH-1:0]            ar_addr,
    output logic [7:0]                       ar_len,
    output logic [2:0]                       ar_size,
    output logic [1:0]                       ar_burst,
    output logic [USER_WIDTH-1:0]            ar_user,
    // r
    input  logic                             r_valid,
    output logic                             r_ready,
    input  logic [ID_WIDTH-1:0]              r_id,
    input  logic [DATA_WIDTH-1:0]            r_data,
    input  logic [1:0]                       r_resp,
    input  logic                             r_last,
    input  logic [USER_WIDTH-1:0]            r_user
);

    localparam int unsigned LineW = LINE_BEATS * DATA_WIDTH;
    localparam int unsigned OffW  = $clog2(LineW / 8);
    localparam int unsigned BeatW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LowMask  = ADDR_WIDTH'((1 << OffW) - 1);
    localparam logic [BeatW-1:0]      LastBeat = BeatW'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        StIdle, StRdAddr, StRdData, StWrAddr, StWrData, StWrResp, StResp
    } state_e;

    state_e            state_q, state_d;
    logic [BeatW-1:0]  beat_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LineW-1:0]  wdata_q;
    logic [LineW-1:0]  rdata_q;
    logic              req_hs, r_hs, w_hs, b_hs, last_beat;
    logic              unused_tags;

    assign req_hs    = req_valid && req_ready;
    assign r_hs      = r_valid && r_ready;
    assign w_hs      = w_valid && w_ready;
    assign b_hs      = b_valid && b_ready;
    assign last_beat = (beat_q == LastBeat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_hs) state_d = req_we ? StWrAddr : StRdAddr;
            StRdAddr: if (ar_ready) state_d = StRdData;
            StRdData: if (r_hs && last_beat) state_d = StResp;
            StWrAddr: if (aw_ready) state_d = StWrData;
            StWrData: if (w_hs && last_beat) state_d = StWrResp;
            StWrResp: if (b_hs) state_d = StResp;
            StResp:   if (rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // req_ready is gated by rst so nothing is offered while reset is held
    always_comb begin
        req_ready = 1'b0;
        ar_valid  = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        r_ready   = 1'b0;
        b_ready   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle:   req_ready = !rst;
            StRdAddr: ar_valid  = 1'b1;
            StRdData: r_ready   = 1'b1;
            StWrAddr: aw_valid  = 1'b1;
            StWrData: w_valid   = 1'b1;
            StWrResp: b_ready   = 1'b1;
            StResp:   rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (req_hs) begin
                addr_q <= req_addr & ~LowMask;
                beat_q <= '0;
                if (req_we) wdata_q <= req_wdata;
            end
            if (r_hs) begin
                rdata_q[beat_q*DATA_WIDTH +: DATA_WIDTH] <= r_data;
                beat_q <= beat_q + BeatW'(1);
            end
            if (w_hs) beat_q <= beat_q + BeatW'(1);
        end
    end

    assign aw_id    = ID_WIDTH'(MASTER_ID);
    assign aw_addr  = addr_q;
    assign aw_len   = 8'(LINE_BEATS - 1);
    assign aw_size  = 3'($clog2(DATA_WIDTH / 8));
    assign aw_burst = 2'b01;
    assign aw_user  = '0;
    assign ar_id    = ID_WIDTH'(MASTER_ID);
    assign ar_addr  = addr_q;
    assign ar_len   = 8'(LINE_BEATS - 1);
    assign ar_size  = 3'($clog2(DATA_WIDTH / 8));
    assign ar_burst = 2'b01;
    assign ar_user  = '0;
    assign w_data   = wdata_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
    assign w_strb   = '1;
    assign w_last   = last_beat;
    assign w_user   = '0;
    assign rsp_rdata = rdata_q;

`ifdef NASTI_LINE_BRIDGE_ERR_EN
    logic err_q;

    // sticky for the current transaction, cleared when the next one is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (req_hs) begin
            err_q <= 1'b0;
        end else if (r_hs && ((r_resp != 2'b00) || (r_last != last_beat))) begin
            err_q <= 1'b1;
        end else if (b_hs && (b_resp != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_err     = err_q;
    assign unused_tags = ^{b_id, b_user, r_id, r_user};
`else
    assign rsp_err     = 1'b0;
    assign unused_tags = ^{b_id, b_user, r_id, r_user, r_resp, b_resp, r_last};
`endif

endmodule

// File: tb/tb_nasti_line_bridge.sv
// Randomized bench for nasti_line_bridge: acts as the NASTI slave over a line-granular memory model.
module tb_nasti_line_bridge;
    localparam int IW = 1, AW = 16, DW = 128, UW = 1, LB = 4, MID = 0;
    localparam int LW = LB * DW;
    localparam int LineBytes = LW / 8;
    localparam int Bound = 64;
`ifdef NASTI_LINE_BRIDGE_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef logic [LW-1:0] line_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [AW-1:0] req_addr;
    line_t req_wdata, rsp_rdata;
    logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [IW-1:0] aw_id, ar_id, b_id, r_id;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [7:0] aw_len, ar_len;
    logic [2:0] aw_size, ar_size;
    logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
    logic [UW-1:0] aw_user, ar_user, w_user, b_user, r_user;
    logic [DW-1:0] w_data, r_data;
    logic [DW/8-1:0] w_strb;

    nasti_line_bridge #(
        .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW),
        .LINE_BEATS(LB), .MASTER_ID(MID)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_user(aw_user),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .w_last(w_last), .w_user(w_user),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_user(ar_user),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
        .r_last(r_last), .r_user(r_user)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    line_t mem [int];
    line_t exp_rdata = '0;
    bit    exp_err   = 1'b0;
    bit    tg        = 1'b0;

    task automatic check_eq(input string tag, input line_t got, input line_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // 0: always, 1: every other cycle, 2: random
    function automatic bit rdy(input int mode);
        tg = ~tg;
        if (mode == 0) return 1'b1;
        if (mode == 1) return tg;
        return 1'($urandom % 2);
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_valids", {ar_valid, aw_valid, w_valid, rsp_valid}, 0);
        check_eq("rst_readies", {r_ready, b_ready}, 0);
        check_eq("rst_rdata", rsp_rdata, 0);
        check_eq("rst_err", rsp_err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_req_ready", req_ready, 1);
        check_eq("post_rst_rsp_valid", rsp_valid, 0);
        exp_rdata = '0;
        exp_err   = 1'b0;
    endtask

    task automatic issue_req(input bit we, input logic [AW-1:0] addr, input line_t data);
        @(negedge clk);
        check_eq("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        @(negedge clk);
        req_valid = 1'b0; req_addr = AW'($urandom); req_wdata = rand_line();
        check_eq("req_ready_busy", req_ready, 0);
    endtask

    task automatic finish_rsp(input int hold);
        check_eq("rsp_valid", rsp_valid, 1);
        for (int i = 0; i < hold; i++) begin
            check_eq("rsp_hold_valid", rsp_valid, 1);
            check_eq("rsp_hold_rdata", rsp_rdata, exp_rdata);
            check_eq("rsp_hold_req_ready", req_ready, 0);
            @(negedge clk);
        end
        check_eq("rsp_rdata", rsp_rdata, exp_rdata);
        check_eq("rsp_err", rsp_err, exp_err);
        check_eq("rsp_req_ready", req_ready, 0);
        // a request offered alongside rsp_ready must not be taken this cycle
        rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'($urandom); req_addr = AW'($urandom);
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        check_eq("rsp_done_valid", rsp_valid, 0);
        check_eq("rsp_done_idle", {req_ready, ar_valid, aw_valid}, 3'b100);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int mode, input int bad_resp_k,
                           input int bad_last_k, input int abort_k, input int hold);
        int idx = int'(addr) / LineBytes;
        logic [AW-1:0] exp_a = AW'(idx * LineBytes);
        line_t line;
        int t;
        if (!mem.exists(idx)) mem[idx] = rand_line();
        line = mem[idx];
        issue_req(1'b0, addr, rand_line());
        check_eq("ar_len", ar_len, LB - 1);
        check_eq("ar_size", ar_size, $clog2(DW / 8));
        check_eq("ar_burst_id_user", {ar_burst, ar_id, ar_user}, {2'b01, IW'(MID), UW'(0)});
        check_eq("r_ready_early", r_ready, 0);
        for (t = 0; t < Bound; t++) begin
            check_eq("ar_valid", ar_valid, 1);
            check_eq("ar_addr", ar_addr, exp_a);
            ar_ready = rdy(mode);
            if (ar_ready) break;
            @(negedge clk);
        end
        check_eq("ar_wait", t < Bound, 1);
        @(negedge clk);
        ar_ready = 1'b0;
        check_eq("ar_dropped", ar_valid, 0);
        for (int k = 0; k < LB; k++) begin
            if (k == abort_k) begin
                apply_reset();
                return;
            end
            for (t = 0; t < Bound; t++) begin
                r_valid = rdy(mode);
                r_data  = line[k*DW +: DW];
                r_last  = ((k == LB - 1) != (k == bad_last_k));
                r_resp  = (k == bad_resp_k) ? 2'b10 : 2'b00;
                if (r_valid && r_ready) break;
                @(negedge clk);
            end
            check_eq("r_wait", t < Bound, 1);
            @(negedge clk);
            r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
        end
        exp_rdata = line;
        exp_err   = ErrEn && ((bad_resp_k >= 0 && bad_resp_k < LB) ||
                              (bad_last_k >= 0 && bad_last_k < LB));
        finish_rsp(hold);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input int mode, input logic [1:0] bresp,
                            input int hold);
        int idx = int'(addr) / LineBytes;
        logic [AW-1:0] exp_a = AW'(idx * LineBytes);
        line_t data = rand_line();
        int t;
        issue_req(1'b1, addr, data);
        check_eq("aw_len", aw_len, LB - 1);
        check_eq("aw_size", aw_size, $clog2(DW / 8));
        check_eq("aw_burst_id_user", {aw_burst, aw_id, aw_user}, {2'b01, IW'(MID), UW'(0)});
        for (t = 0; t < Bound; t++) begin
            check_eq("aw_valid", aw_valid, 1);
            check_eq("aw_addr", aw_addr, exp_a);
            aw_ready = rdy(mode);
            if (aw_ready) break;
            @(negedge clk);
        end
        check_eq("aw_wait", t < Bound, 1);
        @(negedge clk);
        aw_ready = 1'b0;
        check_eq("r_ready_in_write", r_ready, 0);
        for (int k = 0; k < LB; k++) begin
            for (t = 0; t < Bound; t++) begin
                w_ready = rdy(mode);
                if (w_ready) begin
                    check_eq("w_valid", w_valid, 1);
                    check_eq("w_data", w_data, data[k*DW +: DW]);
                    check_eq("w_last", w_last, k == LB - 1);
                    check_eq("w_strb", w_strb, {(DW/8){1'b1}});
                    break;
                end
                @(negedge clk);
            end
            check_eq("w_wait", t < Bound, 1);
            @(negedge clk);
            w_ready = 1'b0;
        end
        for (t = 0; t < Bound; t++) begin
            b_valid = rdy(mode);
            b_resp  = bresp;
            if (b_valid && b_ready) break;
            @(negedge clk);
        end
        check_eq("b_wait", t < Bound, 1);
        @(negedge clk);
        b_valid = 1'b0; b_resp = 2'b00;
        mem[idx] = data;
        exp_err  = ErrEn && (bresp != 2'b00);
        finish_rsp(hold);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        line_t l;
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
        aw_ready = 0; w_ready = 0; ar_ready = 0;
        b_valid = 0; b_id = '0; b_resp = '0; b_user = '0;
        r_valid = 0; r_id = '0; r_data = '0; r_resp = '0; r_last = 0; r_user = '0;
        @(negedge clk);
        apply_reset();

        // known beats 0xA0..0xA3, slave always ready
        for (int k = 0; k < LB; k++) l[k*DW +: DW] = DW'(8'hA0 + k);
        mem[16'h1234 / LineBytes] = l;
        do_read(16'h1234, 0, -1, -1, -1, 0);
        check_eq("known_line", rsp_rdata, l);

        do_write(16'h0040, 1, 2'b00, 0);
        check_eq("write_keeps_rdata", rsp_rdata, l);
        do_read(16'h0040, 2, -1, -1, -1, 5);

        do_write(16'h0080, 0, 2'b10, 1);
        do_read(16'h0080, 0, -1, -1, -1, 0);
        do_read(16'h00C0, 2, -1, 1, -1, 0);
        do_read(16'h0100, 2, 3, -1, -1, 2);

        // reset after the second read beat, then a clean read of fresh data
        do_read(16'h0200, 0, -1, -1, 2, 0);
        mem[16'h0200 / LineBytes] = rand_line();
        do_read(16'h0200, 2, -1, -1, -1, 1);

        for (int i = 0; i < 24; i++) begin
            logic [AW-1:0] a = AW'($urandom_range(0, 7) * LineBytes + $urandom_range(0, 63));
            int mode = $urandom_range(0, 2);
            int hold = $urandom_range(0, 3);
            if ($urandom % 2) begin
                do_write(a, mode, ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00, hold);
            end else begin
                do_read(a, mode, ($urandom % 5 == 0) ? $urandom_range(0, LB - 1) : -1,
                        ($urandom % 5 == 0) ? $urandom_range(0, LB - 1) : -1, -1, hold);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
